fsm_state_monitor: RTL and testbench

Reader side of the vacuum-cleaner FSM's 2-bit state bus. It samples the state code the FSM drives, detects transitions, counts them, and measures how long the FSM has been in the current state in whole seconds. It multiplexes the state number and the dwell time onto the board's 4-digit active-low 7-segment display. It sits beside the FSM in the top level, in the CLK100MHZ domain, as a parallel consumer of the state code that goes to the LEDs.

---
 rtl/fsm_state_monitor.sv | 152 +++++++++++++++
 tb/tb_fsm_state_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_state_monitor.sv
// Passive monitor of the vacuum-cleaner FSM state bus: detects and counts transitions,
// times the dwell in whole seconds and scans state/dwell onto a 4-digit 7-segment display.
module fsm_state_monitor #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned REFRESH_HZ  = 1000,
    parameter int unsigned MAX_SECONDS = 99
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [1:0] state_in,
    output logic [1:0] state_q,
    output logic       change_pulse,
    output logic [7:0] trans_count,
    output logic [6:0] dwell_sec,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned SCAN = CLK_HZ / (REFRESH_HZ * 4);
    localparam int unsigned PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW   = (SCAN > 1) ? $clog2(SCAN) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN - 1);
    localparam logic [6:0]    DWELL_MAX  = 7'(MAX_SECONDS);

    if ((CLK_HZ % (REFRESH_HZ * 4)) != 0 || SCAN < 1) begin : g_bad_scan
        $error("CLK_HZ/(REFRESH_HZ*4) must be an integer >= 1");
    end
    if (MAX_SECONDS > 99) begin : g_bad_max
        $error("MAX_SECONDS must not exceed 99");
    end

    typedef enum logic [1:0] {
        DIG_UNITS = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_BLANK = 2'd2,
        DIG_STATE = 2'd3
    } digit_t;

    logic          change;
    logic [PW-1:0] presc, presc_next;
    logic [6:0]    dwell_next;
    logic [3:0]    tens, units, tens_next, units_next;
    logic [SW-1:0] scan_cnt, scan_next;
    digit_t        digit, digit_next;
    logic [3:0]    shown;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Change has priority over the prescaler wrap; BCD digits track dwell_sec step for step.
    always_comb begin
        change     = (state_in != state_q);
        presc_next = presc;
        dwell_next = dwell_sec;
        tens_next  = tens;
        units_next = units;
        if (change) begin
            presc_next = '0;
            dwell_next = '0;
            tens_next  = '0;
            units_next = '0;
        end else if (presc == PRESC_LAST) begin
            presc_next = '0;
            if (dwell_sec != DWELL_MAX) begin
                dwell_next = dwell_sec + 7'd1;
                if (units == 4'd9) begin
                    units_next = '0;
                    tens_next  = tens + 4'd1;
                end else begin
                    units_next = units + 4'd1;
                end
            end
        end else begin
            presc_next = presc + PW'(1);
        end
    end

    // Display registers are loaded from next-cycle values so digit and content switch together.
    always_comb begin
        scan_next  = scan_cnt + SW'(1);
        digit_next = digit;
        if (scan_cnt == SCAN_LAST) begin
            scan_next = '0;
            case (digit)
                DIG_UNITS: digit_next = DIG_TENS;
                DIG_TENS:  digit_next = DIG_BLANK;
                DIG_BLANK: digit_next = DIG_STATE;
                default:   digit_next = DIG_UNITS;
            endcase
        end
        shown   = 4'hF;
        an_next = 4'b1111;
        case (digit_next)
            DIG_UNITS: begin shown = units_next;        an_next = 4'b1110; end
            DIG_TENS:  begin shown = tens_next;         an_next = 4'b1101; end
            DIG_BLANK: begin shown = 4'hF;              an_next = 4'b1011; end
            default:   begin shown = {2'b00, state_in}; an_next = 4'b0111; end
        endcase
        seg_next = seg_code(shown);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= '0;
            change_pulse <= 1'b0;
            trans_count  <= '0;
            dwell_sec    <= '0;
            presc        <= '0;
            tens         <= '0;
            units        <= '0;
            scan_cnt     <= '0;
            digit        <= DIG_UNITS;
            an           <= 4'b1110;
            seg          <= 7'b1000000;
            dp           <= 1'b1;
        end else begin
            state_q      <= state_in;
            change_pulse <= change;
            if (change) begin
                trans_count <= trans_count + 8'd1;
            end
            dwell_sec    <= dwell_next;
            presc        <= presc_next;
            tens         <= tens_next;
            units        <= units_next;
            scan_cnt     <= scan_next;
            digit        <= digit_next;
            an           <= an_next;
            seg          <= seg_next;
            dp           <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Bench for fsm_state_monitor: vector table, directed corner sequences and random
// stimulus, all checked against a cycles-since-event reference model.
module tb_fsm_state_monitor;

    localparam int unsigned CLK_HZ      = 40;
    localparam int unsigned REFRESH_HZ  = 2;
    localparam int unsigned MAX_SECONDS = 99;
    localparam int unsigned SCAN        = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_in = 2'b00;
    logic [1:0] state_q;
    logic       change_pulse;
    logic [7:0] trans_count;
    logic [6:0] dwell_sec;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    always #5 clk = ~clk;

    fsm_state_monitor #(
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ),
        .MAX_SECONDS(MAX_SECONDS)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .state_in    (state_in),
        .state_q     (state_q),
        .change_pulse(change_pulse),
        .trans_count (trans_count),
        .dwell_sec   (dwell_sec),
        .seg         (seg),
        .an          (an),
        .dp          (dp)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: everything derives from edges since reset and since the last change.
    int unsigned m_state, m_count, m_n, m_c;
    bit          m_pulse;
    logic [6:0]  seg_tab [0:10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                    7'b0000000, 7'b0010000, 7'b1111111};

    typedef struct {
        logic [1:0]  st;
        int unsigned hold;
        int unsigned exp_dwell;
        int unsigned exp_count;
        bit          exp_pulse;
    } vec_t;

    vec_t tab [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned m_dwell();
        int unsigned s;
        s = m_n / CLK_HZ;
        return (s > MAX_SECONDS) ? MAX_SECONDS : s;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_n     = 0;
        m_c     = 0;
        m_pulse = 1'b0;
    endtask

    task automatic model_edge();
        if (32'(state_in) != m_state) begin
            m_pulse = 1'b1;
            m_count = (m_count + 1) % 256;
            m_n     = 0;
        end else begin
            m_pulse = 1'b0;
            m_n     = m_n + 1;
        end
        m_state = 32'(state_in);
        m_c     = m_c + 1;
    endtask

    task automatic check_model();
        int unsigned idx, d, v;
        logic [3:0]  exp_an;
        idx = (m_c / SCAN) % 4;
        d   = m_dwell();
        case (idx)
            0:       v = d % 10;
            1:       v = d / 10;
            2:       v = 10;
            default: v = m_state;
        endcase
        exp_an = 4'b1111 ^ (4'b0001 << idx);
        check("state_q", 32'(state_q), m_state);
        check("change_pulse", 32'(change_pulse), 32'(m_pulse));
        check("trans_count", 32'(trans_count), m_count);
        check("dwell_sec", 32'(dwell_sec), d);
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(seg_tab[v]));
        check("dp", 32'(dp), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_state_q", 32'(state_q), 32'd0);
        check("rst_pulse", 32'(change_pulse), 32'd0);
        check("rst_count", 32'(trans_count), 32'd0);
        check("rst_dwell", 32'(dwell_sec), 32'd0);
        check("rst_an", 32'(an), 32'(4'b1110));
        check("rst_seg", 32'(seg), 32'(7'b1000000));
        check("rst_dp", 32'(dp), 32'd1);
        @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Vector table from a clean reset
        tab[0] = '{st: 2'd0, hold: 100, exp_dwell: 2,  exp_count: 0, exp_pulse: 1'b0};
        tab[1] = '{st: 2'd2, hold: 1,   exp_dwell: 0,  exp_count: 1, exp_pulse: 1'b1};
        tab[2] = '{st: 2'd2, hold: 40,  exp_dwell: 1,  exp_count: 1, exp_pulse: 1'b0};
        tab[3] = '{st: 2'd2, hold: 360, exp_dwell: 10, exp_count: 1, exp_pulse: 1'b0};
        tab[4] = '{st: 2'd1, hold: 1,   exp_dwell: 0,  exp_count: 2, exp_pulse: 1'b1};
        tab[5] = '{st: 2'd3, hold: 1,   exp_dwell: 0,  exp_count: 3, exp_pulse: 1'b1};
        tab[6] = '{st: 2'd3, hold: 79,  exp_dwell: 1,  exp_count: 3, exp_pulse: 1'b0};
        for (int i = 0; i < 7; i++) begin
            state_in = tab[i].st;
            for (int k = 0; k < int'(tab[i].hold); k++) step();
            check("tab_dwell", 32'(dwell_sec), tab[i].exp_dwell);
            check("tab_count", 32'(trans_count), tab[i].exp_count);
            check("tab_pulse", 32'(change_pulse), 32'(tab[i].exp_pulse));
        end

        // Three changes on consecutive cycles
        state_in = 2'd0; step();
        check("burst_p0", 32'(change_pulse), 32'd1);
        check("burst_c0", 32'(trans_count), 32'd4);
        state_in = 2'd1; step();
        check("burst_p1", 32'(change_pulse), 32'd1);
        check("burst_c1", 32'(trans_count), 32'd5);
        state_in = 2'd2; step();
        check("burst_p2", 32'(change_pulse), 32'd1);
        check("burst_c2", 32'(trans_count), 32'd6);
        step();
        check("burst_end", 32'(change_pulse), 32'd0);

        // Change landing on the prescaler's last count
        for (int k = 0; k < 40; k++) step();
        for (int k = 0; k < 40 && (m_n % CLK_HZ) != CLK_HZ - 1; k++) step();
        check("wrap_aligned", m_n % CLK_HZ, CLK_HZ - 1);
        state_in = 2'd1; step();
        check("wrap_dwell", 32'(dwell_sec), 32'd0);
        for (int k = 0; k < 39; k++) step();
        check("wrap_dwell39", 32'(dwell_sec), 32'd0);
        step();
        check("wrap_dwell40", 32'(dwell_sec), 32'd1);

        // Saturation in state 01
        state_in = 2'd0; step();
        state_in = 2'd1; step();
        for (int k = 0; k < 40 * 105; k++) step();
        check("sat_dwell", 32'(dwell_sec), 32'd99);
        for (int k = 0; k < 20; k++) begin
            if (an == 4'b1110 || an == 4'b1101) check("sat_seg9", 32'(seg), 32'(7'b0010000));
            step();
        end

        // 256 changes from reset wrap the counter
        do_reset();
        for (int k = 0; k < 256; k++) begin
            state_in = (k % 2 == 0) ? 2'd1 : 2'd0;
            step();
        end
        check("count_wrap", 32'(trans_count), 32'd0);

        // Mid-count reset, release with 00: no pulse afterwards
        for (int k = 0; k < 7; k++) step();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step();
            check("rel_no_pulse", 32'(change_pulse), 32'd0);
        end

        // Scan pattern with state 11 and dwell 37
        do_reset();
        state_in = 2'd3;
        step();
        for (int k = 0; k < 37 * 40; k++) step();
        for (int k = 0; k < 20 && (m_c % 20) != 0; k++) step();
        begin
            logic [3:0] s_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
            logic [6:0] s_seg [4] = '{7'b1111000, 7'b0110000, 7'b1111111, 7'b0110000};
            check("scan_dwell", 32'(dwell_sec), 32'd37);
            for (int k = 0; k < 20; k++) begin
                check("scan_an", 32'(an), 32'(s_an[k / 5]));
                check("scan_seg", 32'(seg), 32'(s_seg[k / 5]));
                check("scan_dp", 32'(dp), 32'd1);
                step();
            end
        end

        // Random stimulus, occasional async reset with arbitrary state_in
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(599) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(9) == 0) state_in = 2'($urandom_range(3));
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
